// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state, owner and access-size definitions for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {OWN_IFU, OWN_LSU} owner_t;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
endpackage

// File: rtl/mem_lane_gen.sv
// mem_lane_gen: byte strobes, lane-replicated store data and misalignment flag for one access
module mem_lane_gen import mem_arb_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        i_size,
  input  logic [1:0]        i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_we,
  output logic [3:0]        o_wstrb,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_misaligned
);
  logic w_b, w_h;
  assign w_b = i_size == SZ_B;
  assign w_h = i_size == SZ_H;
  assign o_wstrb = !i_we ? 4'b0000 : w_b ? 4'b0001 << i_addr : w_h ? 4'b0011 << {i_addr[1], 1'b0} : 4'b1111;
  assign o_wdata = w_b ? {4{i_wdata[7:0]}} : w_h ? {2{i_wdata[15:0]}} : i_wdata;
  // size 3 falls through to the word rule
  assign o_misaligned = w_h ? i_addr[0] : !w_b && i_addr != 2'b00;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one valid/ready data-memory port between the IFU and the LSU
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_err,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_we,
  input  logic [1:0]        lsu_size,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t            r_state;
  owner_t            r_owner;
  logic [SW-1:0]     r_starve;
  logic [TW-1:0]     r_tmo;
  logic              r_we, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_wstrb;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic              w_idle, w_ifu_pri, w_lsu_gnt, w_ifu_gnt, w_mis;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_wstrb;
  logic [DATA_W-1:0] w_wdata;

  assign w_idle    = r_state == IDLE;
  // a starved IFU overrides the LSU's default priority
  assign w_ifu_pri = ifu_req_valid && r_starve == SW'(STARVE_MAX);
  assign w_lsu_gnt = w_idle && lsu_req_valid && !w_ifu_pri;
  assign w_ifu_gnt = w_idle && ifu_req_valid && !w_lsu_gnt;
  assign w_addr    = w_lsu_gnt ? lsu_addr : ifu_addr;

  mem_lane_gen #(.DATA_W(DATA_W)) u_lane (
    .i_size      (w_lsu_gnt ? lsu_size : SZ_W),
    .i_addr      (w_addr[1:0]),
    .i_wdata     (w_lsu_gnt ? lsu_wdata : '0),
    .i_we        (w_lsu_gnt && lsu_we),
    .o_wstrb     (w_wstrb),
    .o_wdata     (w_wdata),
    .o_misaligned(w_mis)
  );

  assign ifu_req_ready  = w_ifu_gnt;
  assign lsu_req_ready  = w_lsu_gnt;
  assign ifu_resp_valid = r_state == RESP && r_owner == OWN_IFU;
  assign lsu_resp_valid = r_state == RESP && r_owner == OWN_LSU;
  assign ifu_rdata      = r_rdata;
  assign lsu_rdata      = r_rdata;
  assign ifu_err        = r_err;
  assign lsu_err        = r_err;
  assign mem_req_valid  = r_state == ISSUE;
  assign mem_we         = r_we;
  assign mem_addr       = r_addr;
  assign mem_wstrb      = r_wstrb;
  assign mem_wdata      = r_wdata;
  assign busy           = !w_idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_owner  <= OWN_IFU;
      r_starve <= '0;
      r_tmo    <= '0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_wstrb  <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      r_starve <= (!ifu_req_valid || w_ifu_gnt) ? '0 :
                  (w_lsu_gnt && r_starve != SW'(STARVE_MAX)) ? r_starve + SW'(1) : r_starve;
      case (r_state)
        IDLE: if (w_lsu_gnt || w_ifu_gnt) begin
          r_owner <= w_lsu_gnt ? OWN_LSU : OWN_IFU;
          r_we    <= w_lsu_gnt && lsu_we;
          r_addr  <= {w_addr[ADDR_W-1:2], 2'b00};
          r_wstrb <= w_wstrb;
          r_wdata <= w_wdata;
          r_rdata <= '0;
          r_err   <= w_mis;
          r_state <= w_mis ? RESP : ISSUE;
        end
        ISSUE: if (mem_req_ready) begin
          r_tmo   <= '0;
          r_state <= WAIT;
        end
        WAIT: if (mem_resp_valid) begin
          r_rdata <= r_we ? '0 : mem_rdata;
          r_err   <= 1'b0;
          r_state <= RESP;
        end else if (r_tmo == TW'(TIMEOUT - 1)) begin
          r_rdata <= '0;
          r_err   <= 1'b1;
          r_state <= RESP;
        end else begin
          r_tmo <= r_tmo + TW'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
